// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the N-port memory arbiter and its per-port trackers.
package mem_arb_pkg;

  typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_t;

  localparam int MEM_ADDR_W = 30;
  localparam int MEM_RLEN_W = 5;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_WBE_W  = 4;

endpackage

// File: rtl/port_read_tracker.sv
// Per-port outstanding read-word counter: eligibility against the word budget,
// increment on an acked read, decrement on each response beat, underflow detect.
module port_read_tracker
  import mem_arb_pkg::*;
#(
  parameter int MAX_WORDS = 32,
  parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  is_read,
  input  logic [MEM_RLEN_W-1:0] rlen,
  input  logic                  issue,
  input  logic                  beat,
  output logic                  eligible,
  output logic                  underflow,
  output logic [CNT_W-1:0]      pending
);

  localparam logic [CNT_W:0] ONE   = (CNT_W + 1)'(1);
  localparam logic [CNT_W:0] MAX_C = (CNT_W + 1)'(MAX_WORDS);

  logic [CNT_W:0] burst;
  logic [CNT_W:0] need;
  logic [CNT_W:0] next_cnt;

  assign burst = (CNT_W + 1)'(rlen) + ONE;
  assign need  = {1'b0, pending} + burst;

  // rmw is counted like a read, so it is budget-checked like one too.
  assign eligible  = req & (~is_read | (need <= MAX_C));
  assign underflow = beat & (pending == '0);

  // A beat against an empty counter holds it at zero; the top flags err.
  assign next_cnt = {1'b0, pending} + (issue ? burst : '0)
                  - ((beat && pending != '0) ? ONE : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else if (issue || beat) begin
      pending <= CNT_W'(next_cnt);
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-port memory arbiter: round-robin or fixed priority, grant locked until mem_ack,
// per-port read-word budgets, responses routed by mem_rid. Handshake: a port holds
// req (and its addr/rlen/rnw/rmw) until the cycle ack[p]=1; ack is combinational.
module mem_arbiter_n
  import mem_arb_pkg::*;
#(
  parameter int        NUM_PORTS = 4,
  parameter int        ID_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  parameter arb_mode_t ARB_MODE  = ARB_RR,
  parameter int        MAX_WORDS = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_PORTS-1:0]                   req,
  input  logic [NUM_PORTS-1:0][MEM_ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS-1:0][MEM_RLEN_W-1:0]   rlen,
  input  logic [NUM_PORTS-1:0]                   rnw,
  input  logic [NUM_PORTS-1:0]                   rmw,
  output logic [NUM_PORTS-1:0]                   ack,
  output logic [NUM_PORTS-1:0]                   rvalid,
  output logic [MEM_DATA_W-1:0]                  rdata,
  input  logic [MEM_WBE_W-1:0]                   wbe,
  input  logic [MEM_DATA_W-1:0]                  wdata,
  output logic                                   mem_request,
  output logic [MEM_ADDR_W-1:0]                  mem_addr,
  output logic [MEM_RLEN_W-1:0]                  mem_rlen,
  output logic                                   mem_rnw,
  output logic                                   mem_rmw,
  output logic [ID_W-1:0]                        mem_id,
  output logic [MEM_WBE_W-1:0]                   mem_wbe,
  output logic [MEM_DATA_W-1:0]                  mem_wdata,
  input  logic                                   mem_ack,
  input  logic                                   mem_rvalid,
  input  logic [ID_W-1:0]                        mem_rid,
  input  logic [MEM_DATA_W-1:0]                  mem_rdata,
  output logic                                   err,
  output logic                                   dbg_locked,
  output logic [ID_W-1:0]                        dbg_ptr,
  output logic [NUM_PORTS-1:0][$clog2(MAX_WORDS+1)-1:0] dbg_pending
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] underflow;
  logic                 locked;
  logic [ID_W-1:0]      lock_sel;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      pick;
  logic [ID_W-1:0]      sel;
  logic                 found;
  logic                 grant;
  logic                 rid_ok;

  // Search order starts at ptr for round-robin and at 0 for fixed priority.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (ARB_MODE == ARB_RR) ? int'(ptr) + i : i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  assign sel         = locked ? lock_sel : pick;
  assign mem_request = locked | found;
  assign grant       = mem_request & mem_ack;

  assign mem_addr  = addr[sel];
  assign mem_rlen  = rlen[sel];
  assign mem_rnw   = rnw[sel];
  assign mem_rmw   = rmw[sel];
  assign mem_id    = sel;
  assign mem_wbe   = wbe;
  assign mem_wdata = wdata;
  assign rdata     = mem_rdata;

  always_comb begin
    ack = '0;
    if (grant) ack[sel] = 1'b1;
  end

  assign rid_ok = int'(mem_rid) < NUM_PORTS;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic beat;
    assign beat      = mem_rvalid & rid_ok & (mem_rid == ID_W'(p));
    assign rvalid[p] = beat;

    port_read_tracker #(
      .MAX_WORDS(MAX_WORDS),
      .CNT_W    (CNT_W)
    ) u_tracker (
      .clk      (clk),
      .rst      (rst),
      .req      (req[p]),
      .is_read  (rnw[p] | rmw[p]),
      .rlen     (rlen[p]),
      .issue    (ack[p] & (rnw[p] | rmw[p])),
      .beat     (beat),
      .eligible (eligible[p]),
      .underflow(underflow[p]),
      .pending  (dbg_pending[p])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked   <= 1'b0;
      lock_sel <= '0;
      ptr      <= '0;
      err      <= 1'b0;
    end else begin
      if (mem_request && !mem_ack) begin
        locked   <= 1'b1;
        lock_sel <= sel;
      end else if (grant) begin
        locked <= 1'b0;
      end
      if (grant && ARB_MODE == ARB_RR) begin
        ptr <= (int'(sel) + 1 >= NUM_PORTS) ? '0 : sel + ID_W'(1);
      end
      if ((mem_rvalid && !rid_ok) || (|underflow)) begin
        err <= 1'b1;
      end
    end
  end

  assign dbg_locked = locked;
  assign dbg_ptr    = ptr;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n: a 4-port round-robin instance and a 3-port
// fixed-priority instance share clock and reset.
module tb_mem_arbiter_n;
  import mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  // ---------------- round-robin instance (4 ports) ----------------
  logic [3:0]       r_req, r_rnw, r_rmw, r_ack, r_rvalid;
  logic [3:0][29:0] r_addr;
  logic [3:0][4:0]  r_rlen;
  logic [31:0]      r_rdata, r_wdata, r_mem_wdata, r_mem_rdata;
  logic [3:0]       r_wbe, r_mem_wbe;
  logic             r_mem_request, r_mem_rnw, r_mem_rmw, r_mem_ack, r_mem_rvalid, r_err, r_dbg_locked;
  logic [29:0]      r_mem_addr;
  logic [4:0]       r_mem_rlen;
  logic [1:0]       r_mem_id, r_mem_rid, r_dbg_ptr;
  logic [3:0][5:0]  r_dbg_pending;

  mem_arbiter_n #(.NUM_PORTS(4), .ARB_MODE(ARB_RR), .MAX_WORDS(32)) u_rr (
    .clk(clk), .rst(rst), .req(r_req), .addr(r_addr), .rlen(r_rlen), .rnw(r_rnw), .rmw(r_rmw),
    .ack(r_ack), .rvalid(r_rvalid), .rdata(r_rdata), .wbe(r_wbe), .wdata(r_wdata),
    .mem_request(r_mem_request), .mem_addr(r_mem_addr), .mem_rlen(r_mem_rlen),
    .mem_rnw(r_mem_rnw), .mem_rmw(r_mem_rmw), .mem_id(r_mem_id), .mem_wbe(r_mem_wbe),
    .mem_wdata(r_mem_wdata), .mem_ack(r_mem_ack), .mem_rvalid(r_mem_rvalid),
    .mem_rid(r_mem_rid), .mem_rdata(r_mem_rdata), .err(r_err),
    .dbg_locked(r_dbg_locked), .dbg_ptr(r_dbg_ptr), .dbg_pending(r_dbg_pending)
  );

  // ---------------- fixed-priority instance (3 ports) ----------------
  logic [2:0]       f_req, f_rnw, f_rmw, f_ack, f_rvalid;
  logic [2:0][29:0] f_addr;
  logic [2:0][4:0]  f_rlen;
  logic [31:0]      f_rdata, f_wdata, f_mem_wdata, f_mem_rdata;
  logic [3:0]       f_wbe, f_mem_wbe;
  logic             f_mem_request, f_mem_rnw, f_mem_rmw, f_mem_ack, f_mem_rvalid, f_err, f_dbg_locked;
  logic [29:0]      f_mem_addr;
  logic [4:0]       f_mem_rlen;
  logic [1:0]       f_mem_id, f_mem_rid, f_dbg_ptr;
  logic [2:0][5:0]  f_dbg_pending;

  mem_arbiter_n #(.NUM_PORTS(3), .ARB_MODE(ARB_FIXED), .MAX_WORDS(32)) u_fx (
    .clk(clk), .rst(rst), .req(f_req), .addr(f_addr), .rlen(f_rlen), .rnw(f_rnw), .rmw(f_rmw),
    .ack(f_ack), .rvalid(f_rvalid), .rdata(f_rdata), .wbe(f_wbe), .wdata(f_wdata),
    .mem_request(f_mem_request), .mem_addr(f_mem_addr), .mem_rlen(f_mem_rlen),
    .mem_rnw(f_mem_rnw), .mem_rmw(f_mem_rmw), .mem_id(f_mem_id), .mem_wbe(f_mem_wbe),
    .mem_wdata(f_mem_wdata), .mem_ack(f_mem_ack), .mem_rvalid(f_mem_rvalid),
    .mem_rid(f_mem_rid), .mem_rdata(f_mem_rdata), .err(f_err),
    .dbg_locked(f_dbg_locked), .dbg_ptr(f_dbg_ptr), .dbg_pending(f_dbg_pending)
  );

  // ---------------- driver tasks ----------------
  task automatic idle();
    r_req = '0; r_rnw = '0; r_rmw = '0; r_rlen = '0; r_wbe = '0; r_wdata = '0;
    r_mem_ack = 1'b0; r_mem_rvalid = 1'b0; r_mem_rid = '0; r_mem_rdata = '0;
    for (int p = 0; p < 4; p++) r_addr[p] = 30'(32'h100 + p);
    f_req = '0; f_rnw = '0; f_rmw = '0; f_rlen = '0; f_wbe = '0; f_wdata = '0;
    f_mem_ack = 1'b0; f_mem_rvalid = 1'b0; f_mem_rid = '0; f_mem_rdata = '0;
    for (int p = 0; p < 3; p++) f_addr[p] = 30'(32'h200 + p);
  endtask

  // Returns a read beat to port rid of the RR instance, n times.
  task automatic rr_beats(input logic [1:0] rid, input int n);
    for (int i = 0; i < n; i++) begin
      r_mem_rvalid = 1'b1; r_mem_rid = rid;
      @(negedge clk);
    end
    r_mem_rvalid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    #2;
    n_cmp++;
    if (r_mem_request !== 1'b0 || r_ack !== 4'b0 || r_rvalid !== 4'b0 || r_err !== 1'b0) begin
      $display("FAIL reset_rr_outputs req=%b ack=%b rvalid=%b err=%b exp 0/0000/0000/0",
               r_mem_request, r_ack, r_rvalid, r_err); n_fail++;
    end
    n_cmp++;
    if (r_dbg_pending !== 24'h0 || r_dbg_ptr !== 2'd0 || r_dbg_locked !== 1'b0) begin
      $display("FAIL reset_rr_state pending=%h ptr=%0d locked=%b exp 0/0/0",
               r_dbg_pending, r_dbg_ptr, r_dbg_locked); n_fail++;
    end
    n_cmp++;
    if (f_mem_request !== 1'b0 || f_ack !== 3'b0 || f_err !== 1'b0 || f_dbg_pending !== 18'h0) begin
      $display("FAIL reset_fx req=%b ack=%b err=%b pending=%h exp 0/000/0/0",
               f_mem_request, f_ack, f_err, f_dbg_pending); n_fail++;
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_rr_order();
    logic [3:0] exp_ack;
    logic [5:0] exp_pend[4] = '{6'd2, 6'd1, 6'd1, 6'd1};
    int         rids[5] = '{0, 0, 1, 2, 3};
    @(negedge clk);
    r_req = 4'hF; r_rnw = 4'hF; r_rlen = '0; r_mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_ack = 4'(1 << (i % 4));
      n_cmp++;
      if (r_ack !== exp_ack || r_mem_id !== 2'(i % 4) || r_mem_addr !== 30'(32'h100 + i % 4)) begin
        $display("FAIL rr_order[%0d] ack=%b id=%0d addr=%h exp ack=%b id=%0d addr=%h", i,
                 r_ack, r_mem_id, r_mem_addr, exp_ack, i % 4, 32'h100 + i % 4); n_fail++;
      end
      @(negedge clk);
    end
    r_req = '0; r_mem_ack = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (r_dbg_pending[p] !== exp_pend[p]) begin
        $display("FAIL rr_pending[%0d] got=%0d exp=%0d", p, r_dbg_pending[p], exp_pend[p]); n_fail++;
      end
    end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      r_mem_rvalid = 1'b1; r_mem_rid = 2'(rids[i]); r_mem_rdata = 32'hA000_0000 + 32'(i);
      exp_q.push_back(32'hA000_0000 + 32'(i));
      #1;
      n_cmp++;
      if (r_rvalid !== 4'(1 << rids[i]) || r_rdata !== exp_q.pop_front()) begin
        $display("FAIL rr_route[%0d] rvalid=%b rdata=%h exp rvalid=%b rdata=%h", i, r_rvalid,
                 r_rdata, 4'(1 << rids[i]), 32'hA000_0000 + 32'(i)); n_fail++;
      end
      @(negedge clk);
    end
    r_mem_rvalid = 1'b0;
    #1;
    n_cmp++;
    if (r_dbg_pending !== 24'h0 || r_err !== 1'b0) begin
      $display("FAIL rr_drain pending=%h err=%b exp 0/0", r_dbg_pending, r_err); n_fail++;
    end
  endtask

  task automatic test_lock();
    @(negedge clk);
    r_req = 4'b0011; r_rnw = 4'b0011; r_rlen = '0; r_mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (r_mem_request !== 1'b1 || r_mem_id !== 2'd1 || r_ack !== 4'b0) begin
        $display("FAIL lock_hold[%0d] req=%b id=%0d ack=%b exp 1/1/0000", i,
                 r_mem_request, r_mem_id, r_ack); n_fail++;
      end
      @(negedge clk);
    end
    r_mem_ack = 1'b1;
    #1;
    n_cmp++;
    if (r_ack !== 4'b0010 || r_dbg_locked !== 1'b1) begin
      $display("FAIL lock_ack ack=%b locked=%b exp 0010/1", r_ack, r_dbg_locked); n_fail++;
    end
    @(negedge clk);
    r_req = 4'b0001;
    #1;
    n_cmp++;
    if (r_ack !== 4'b0001 || r_mem_id !== 2'd0 || r_dbg_locked !== 1'b0) begin
      $display("FAIL lock_next ack=%b id=%0d locked=%b exp 0001/0/0", r_ack, r_mem_id, r_dbg_locked); n_fail++;
    end
    @(negedge clk);
    r_req = '0; r_mem_ack = 1'b0;
    rr_beats(2'd1, 1);
    rr_beats(2'd0, 1);
  endtask

  task automatic test_budget();
    @(negedge clk);
    r_req = 4'b0100; r_rnw = 4'b0100; r_rlen = '0; r_rlen[2] = 5'd31; r_mem_ack = 1'b1;
    #1;
    n_cmp++;
    if (r_ack !== 4'b0100 || r_mem_rlen !== 5'd31) begin
      $display("FAIL budget_full_burst ack=%b rlen=%0d exp 0100/31", r_ack, r_mem_rlen); n_fail++;
    end
    @(negedge clk);
    r_rlen[2] = 5'd0;
    #1;
    n_cmp++;
    if (r_mem_request !== 1'b0 || r_ack !== 4'b0 || r_dbg_pending[2] !== 6'd32) begin
      $display("FAIL budget_block req=%b ack=%b pending=%0d exp 0/0000/32",
               r_mem_request, r_ack, r_dbg_pending[2]); n_fail++;
    end
    @(negedge clk);
    r_mem_rvalid = 1'b1; r_mem_rid = 2'd2;
    #1;
    n_cmp++;
    if (r_mem_request !== 1'b0 || r_rvalid !== 4'b0100) begin
      $display("FAIL budget_beat req=%b rvalid=%b exp 0/0100", r_mem_request, r_rvalid); n_fail++;
    end
    @(negedge clk);
    r_mem_rvalid = 1'b0;
    #1;
    n_cmp++;
    if (r_ack !== 4'b0100 || r_dbg_pending[2] !== 6'd31) begin
      $display("FAIL budget_release ack=%b pending=%0d exp 0100/31", r_ack, r_dbg_pending[2]); n_fail++;
    end
    @(negedge clk);
    r_req = '0; r_mem_ack = 1'b0;
    rr_beats(2'd2, 32);
    #1;
    n_cmp++;
    if (r_dbg_pending[2] !== 6'd0 || r_err !== 1'b0) begin
      $display("FAIL budget_drain pending=%0d err=%b exp 0/0", r_dbg_pending[2], r_err); n_fail++;
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    r_req = 4'b0001; r_rnw = 4'b0001; r_rlen = '0; r_rlen[0] = 5'd1; r_mem_ack = 1'b1;
    @(negedge clk);
    r_rlen[0] = 5'd3; r_mem_rvalid = 1'b1; r_mem_rid = 2'd0;
    #1;
    n_cmp++;
    if (r_dbg_pending[0] !== 6'd2 || r_ack !== 4'b0001 || r_rvalid !== 4'b0001) begin
      $display("FAIL same_pre pending=%0d ack=%b rvalid=%b exp 2/0001/0001",
               r_dbg_pending[0], r_ack, r_rvalid); n_fail++;
    end
    @(negedge clk);
    r_req = '0; r_mem_ack = 1'b0; r_mem_rvalid = 1'b0;
    #1;
    n_cmp++;
    if (r_dbg_pending[0] !== 6'd5) begin
      $display("FAIL same_net pending=%0d exp 5", r_dbg_pending[0]); n_fail++;
    end
    @(negedge clk);
    rr_beats(2'd0, 5);
    #1;
    n_cmp++;
    if (r_dbg_pending[0] !== 6'd0 || r_err !== 1'b0) begin
      $display("FAIL same_drain pending=%0d err=%b exp 0/0", r_dbg_pending[0], r_err); n_fail++;
    end
  endtask

  task automatic test_fixed();
    @(negedge clk);
    f_req = 3'b110; f_rnw = 3'b110; f_rlen = '0; f_mem_ack = 1'b1;
    #1;
    n_cmp++;
    if (f_ack !== 3'b010 || f_mem_id !== 2'd1) begin
      $display("FAIL fixed_prio ack=%b id=%0d exp 010/1", f_ack, f_mem_id); n_fail++;
    end
    @(negedge clk);
    f_req = 3'b100;
    #1;
    n_cmp++;
    if (f_ack !== 3'b100) begin
      $display("FAIL fixed_second ack=%b exp 100", f_ack); n_fail++;
    end
    @(negedge clk);
    f_req = 3'b001; f_rnw = 3'b000; f_wbe = 4'hF; f_wdata = 32'hDEAD_BEEF; f_addr[0] = 30'h3ABC;
    #1;
    n_cmp++;
    if (f_ack !== 3'b001 || f_mem_rnw !== 1'b0 || f_mem_wdata !== 32'hDEAD_BEEF ||
        f_mem_wbe !== 4'hF || f_mem_addr !== 30'h3ABC) begin
      $display("FAIL fixed_write ack=%b rnw=%b wdata=%h wbe=%h addr=%h exp 001/0/deadbeef/f/3abc",
               f_ack, f_mem_rnw, f_mem_wdata, f_mem_wbe, f_mem_addr); n_fail++;
    end
    @(negedge clk);
    f_req = '0; f_mem_ack = 1'b0;
    #1;
    n_cmp++;
    if (f_dbg_pending[0] !== 6'd0 || f_dbg_pending[1] !== 6'd1 || f_dbg_pending[2] !== 6'd1) begin
      $display("FAIL fixed_pending got=%0d,%0d,%0d exp 0,1,1",
               f_dbg_pending[0], f_dbg_pending[1], f_dbg_pending[2]); n_fail++;
    end
    // Port 2 takes the lock, then a higher-priority port 0 arrives.
    @(negedge clk);
    f_req = 3'b100; f_rnw = 3'b100;
    @(negedge clk);
    f_req = 3'b101; f_rnw = 3'b101;
    #1;
    n_cmp++;
    if (f_mem_id !== 2'd2 || f_ack !== 3'b000 || f_mem_request !== 1'b1) begin
      $display("FAIL fixed_lock id=%0d ack=%b req=%b exp 2/000/1", f_mem_id, f_ack, f_mem_request); n_fail++;
    end
    @(negedge clk);
    f_mem_ack = 1'b1;
    #1;
    n_cmp++;
    if (f_ack !== 3'b100) begin
      $display("FAIL fixed_lock_ack ack=%b exp 100", f_ack); n_fail++;
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (f_ack !== 3'b001) begin
      $display("FAIL fixed_after_lock ack=%b exp 001", f_ack); n_fail++;
    end
    @(negedge clk);
    f_req = '0; f_mem_ack = 1'b0;
  endtask

  task automatic test_bad_rid_and_reset();
    @(negedge clk);
    f_mem_rvalid = 1'b1; f_mem_rid = 2'd3;
    #1;
    n_cmp++;
    if (f_rvalid !== 3'b000 || f_err !== 1'b0) begin
      $display("FAIL bad_rid_drop rvalid=%b err=%b exp 000/0", f_rvalid, f_err); n_fail++;
    end
    @(negedge clk);
    f_mem_rvalid = 1'b0;
    #1;
    n_cmp++;
    if (f_err !== 1'b1 || f_dbg_pending[2] !== 6'd2 || f_dbg_pending[0] !== 6'd1) begin
      $display("FAIL bad_rid_err err=%b pending2=%0d pending0=%0d exp 1/2/1",
               f_err, f_dbg_pending[2], f_dbg_pending[0]); n_fail++;
    end
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (f_err !== 1'b0 || f_dbg_pending !== 18'h0 || f_dbg_locked !== 1'b0) begin
      $display("FAIL async_reset err=%b pending=%h locked=%b exp 0/0/0",
               f_err, f_dbg_pending, f_dbg_locked); n_fail++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    f_mem_rvalid = 1'b1; f_mem_rid = 2'd2;
    #1;
    n_cmp++;
    if (f_rvalid !== 3'b100) begin
      $display("FAIL stale_beat_route rvalid=%b exp 100", f_rvalid); n_fail++;
    end
    @(negedge clk);
    f_mem_rvalid = 1'b0;
    #1;
    n_cmp++;
    if (f_err !== 1'b1 || f_dbg_pending[2] !== 6'd0) begin
      $display("FAIL stale_beat_err err=%b pending=%0d exp 1/0", f_err, f_dbg_pending[2]); n_fail++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rr_order();
    test_lock();
    test_budget();
    test_same_cycle();
    test_fixed();
    test_bad_rid_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
